// File: rtl/nvmain_pkg.sv
// Shared definitions for the NVMain command sequencer: opcode constants,
// opcode classification helpers and the sequencer FSM state encoding.
package nvmain_pkg;

    localparam logic [7:0] OP_C_NB = 8'h63;  // 'c'
    localparam logic [7:0] OP_C_B  = 8'h43;  // 'C'
    localparam logic [7:0] OP_L_NB = 8'h6C;  // 'l'
    localparam logic [7:0] OP_L_B  = 8'h4C;  // 'L'
    localparam logic [7:0] OP_R_NB = 8'h72;  // 'r'
    localparam logic [7:0] OP_R_B  = 8'h52;  // 'R'
    localparam logic [7:0] OP_W_NB = 8'h77;  // 'w'
    localparam logic [7:0] OP_W_B  = 8'h57;  // 'W'

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT
    } state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        case (op)
            OP_C_NB, OP_C_B, OP_L_NB, OP_L_B,
            OP_R_NB, OP_R_B, OP_W_NB, OP_W_B: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Uppercase opcodes wait for bridge_done before the queue advances.
    function automatic logic is_blocking_op(input logic [7:0] op);
        case (op)
            OP_C_B, OP_L_B, OP_R_B, OP_W_B: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nvmain_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
// Read data is combinational from the head entry, valid in the pop cycle.
module nvmain_cmd_fifo #(
    parameter int W     = 112,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop may happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/nvmain_cmd_sequencer.sv
// NVMain command sequencer: queues driver commands and issues them to the
// VPI bridge as one-cycle command_enable strobes, enforcing a minimum strobe
// spacing, blocking-op completion with timeout, and illegal-opcode screening.
// Optional statistics counters are enabled with `define NVMAIN_CMD_STATS_EN.
module nvmain_cmd_sequencer
    import nvmain_pkg::*;
#(
    parameter int ARG_W   = 32,
    parameter int DEPTH   = 8,
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg1,
    input  logic [ARG_W-1:0] cmd_arg2,
    input  logic [ARG_W-1:0] cmd_arg3,
    input  logic [7:0]       cmd_arg4,
    input  logic             bridge_busy,
    input  logic             bridge_done,
    output logic             command_enable,
    output logic [7:0]       arg0,
    output logic [ARG_W-1:0] arg1,
    output logic [ARG_W-1:0] arg2,
    output logic [ARG_W-1:0] arg3,
    output logic [7:0]       arg4,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic             idle
`ifdef NVMAIN_CMD_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [15:0]      stat_illegal,
    output logic [15:0]      stat_timeout
`endif
);

    localparam int ENTRY_W = 8 + 3 * ARG_W + 8;
    localparam int GAP_W   = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               blk_q;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] pop_data;
    logic [7:0]         head_op;
    logic [ARG_W-1:0]   head_a1;
    logic [ARG_W-1:0]   head_a2;
    logic [ARG_W-1:0]   head_a3;
    logic [7:0]         head_a4;
    logic               head_legal;
    logic               issue_evt;
    logic               drop_evt;
    logic               to_evt;

    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == S_IDLE) && !empty && !bridge_busy;
    assign idle       = empty && (state == S_IDLE);

    assign head_op    = pop_data[ENTRY_W-1 -: 8];
    assign head_a1    = pop_data[ENTRY_W-9 -: ARG_W];
    assign head_a2    = pop_data[8+2*ARG_W-1 -: ARG_W];
    assign head_a3    = pop_data[8+ARG_W-1 -: ARG_W];
    assign head_a4    = pop_data[7:0];
    assign head_legal = is_legal_op(head_op);

    assign issue_evt  = pop && head_legal;
    assign drop_evt   = pop && !head_legal;
    assign to_evt     = (state == S_WAIT) && !bridge_done && (to_cnt == TO_W'(TIMEOUT - 1));

    nvmain_cmd_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cmd_op, cmd_arg1, cmd_arg2, cmd_arg3, cmd_arg4}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty)
    );

    // Issue FSM. The gap counter runs from the strobe cycle onward (through
    // S_WAIT as well), so a late bridge_done only costs one S_GAP cycle while
    // back-to-back non-blocking strobes land exactly MIN_GAP apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            command_enable <= 1'b0;
            arg0           <= '0;
            arg1           <= '0;
            arg2           <= '0;
            arg3           <= '0;
            arg4           <= '0;
            err_illegal    <= 1'b0;
            err_timeout    <= 1'b0;
            gap_cnt        <= '0;
            to_cnt         <= '0;
            blk_q          <= 1'b0;
        end else begin
            command_enable <= 1'b0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            case (state)
                S_IDLE: begin
                    if (issue_evt) begin
                        arg0           <= head_op;
                        arg1           <= head_a1;
                        arg2           <= head_a2;
                        arg3           <= head_a3;
                        arg4           <= head_a4;
                        blk_q          <= is_blocking_op(head_op);
                        gap_cnt        <= GAP_W'(MIN_GAP - 2);
                        to_cnt         <= '0;
                        command_enable <= 1'b1;
                        state          <= S_ISSUE;
                    end else if (drop_evt) begin
                        err_illegal <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (blk_q && !bridge_done) state <= S_WAIT;
                    else if (gap_cnt == '0)     state <= S_IDLE;
                    else                        state <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                end
                S_WAIT: begin
                    if (bridge_done) begin
                        state <= S_GAP;
                    end else if (to_evt) begin
                        err_timeout <= 1'b1;
                        state       <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NVMAIN_CMD_STATS_EN
    // Saturating event counters for issued, dropped and timed-out commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
            stat_timeout <= '0;
        end else begin
            if (issue_evt && (stat_issued  != '1)) stat_issued  <= stat_issued  + 32'd1;
            if (drop_evt  && (stat_illegal != '1)) stat_illegal <= stat_illegal + 16'd1;
            if (to_evt    && (stat_timeout != '1)) stat_timeout <= stat_timeout + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nvmain_cmd_sequencer.sv
// Scoreboard bench for nvmain_cmd_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them whenever command_enable is seen.
module tb_nvmain_cmd_sequencer;

    localparam int ARG_W   = 32;
    localparam int DEPTH   = 8;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 1024;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg1, cmd_arg2, cmd_arg3;
    logic [7:0]       cmd_arg4;
    logic             bridge_busy, bridge_done;
    logic             command_enable;
    logic [7:0]       arg0, arg4;
    logic [ARG_W-1:0] arg1, arg2, arg3;
    logic             err_illegal, err_timeout, idle;
`ifdef NVMAIN_CMD_STATS_EN
    logic [31:0]      stat_issued;
    logic [15:0]      stat_illegal, stat_timeout;
`endif

    nvmain_cmd_sequencer #(
        .ARG_W   (ARG_W),
        .DEPTH   (DEPTH),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg1       (cmd_arg1),
        .cmd_arg2       (cmd_arg2),
        .cmd_arg3       (cmd_arg3),
        .cmd_arg4       (cmd_arg4),
        .bridge_busy    (bridge_busy),
        .bridge_done    (bridge_done),
        .command_enable (command_enable),
        .arg0           (arg0),
        .arg1           (arg1),
        .arg2           (arg2),
        .arg3           (arg3),
        .arg4           (arg4),
        .err_illegal    (err_illegal),
        .err_timeout    (err_timeout),
        .idle           (idle)
`ifdef NVMAIN_CMD_STATS_EN
        ,
        .stat_issued    (stat_issued),
        .stat_illegal   (stat_illegal),
        .stat_timeout   (stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a1, a2, a3;
        logic [7:0]  a4;
        int          exp_cyc;   // -1: not checked
        int          exp_gap;   // -1: not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_strobe = -1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_strobe(input logic [7:0] op, input logic [31:0] a1, a2, a3,
                                 input logic [7:0] a4, input int ec, input int eg);
        exp_t e;
        e.op = op; e.a1 = a1; e.a2 = a2; e.a3 = a3; e.a4 = a4;
        e.exp_cyc = ec; e.exp_gap = eg;
        sb.push_back(e);
    endtask

    // Called at a negedge; offers the command for one cycle once cmd_ready is high.
    task automatic push_cmd(input logic [7:0] op, input logic [31:0] a1, a2, a3, input logic [7:0] a4);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_wait: cmd_ready stayed 0 for %0d cycles, required 1", t);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg1  = a1;
        cmd_arg2  = a2;
        cmd_arg3  = a3;
        cmd_arg4  = a4;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((sb.size() != 0 || !idle) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d strobes outstanding, idle=%0b after %0d cycles, required 0 and 1",
                     sb.size(), idle, budget);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (command_enable) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: strobe op=%0h at cycle %0d, required none", arg0, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_args", {arg0, arg1, arg2, arg3, arg4},
                      {mon_e.op, mon_e.a1, mon_e.a2, mon_e.a3, mon_e.a4});
                if (mon_e.exp_cyc >= 0) check("strobe_cycle", cyc, mon_e.exp_cyc);
                if (mon_e.exp_gap >= 0) check("strobe_gap", cyc - last_strobe, mon_e.exp_gap);
            end
            last_strobe = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] t5_ops [8] = '{8'h77, 8'h72, 8'h6C, 8'h63, 8'h77, 8'h72, 8'h6C, 8'h63};

    initial begin
        int k, s;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_arg1    = '0;
        cmd_arg2    = '0;
        cmd_arg3    = '0;
        cmd_arg4    = '0;
        bridge_busy = 1'b0;
        bridge_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_enable", command_enable, 0);
        check("rst_args", {arg0, arg1, arg2, arg3, arg4}, 0);
        check("rst_errs", {err_illegal, err_timeout}, 0);

        // 1: non-blocking 'c', latency 2, idle at strobe+MIN_GAP-1
        k = cyc;
        expect_strobe(8'h63, 32'd384, 32'd191991292, 32'd12331, 8'h58, k + 2, -1);
        push_cmd(8'h63, 32'd384, 32'd191991292, 32'd12331, 8'h58);
        wait_to(k + 2 + MIN_GAP - 2);
        check("t1_not_idle_in_gap", idle, 0);
        wait_to(k + 2 + MIN_GAP - 1);
        check("t1_idle", idle, 1);
        check("t1_arg0_held", arg0, 8'h63);
`ifdef NVMAIN_CMD_STATS_EN
        check("t1_stat_issued", stat_issued, 1);
`endif

        // 2: blocking 'C', done 5 cycles after strobe, next op at done+MIN_GAP-1
        k = cyc;
        expect_strobe(8'h43, 32'd384, 32'd191991292, 32'd12331, 8'h58, k + 2, -1);
        expect_strobe(8'h77, 32'h11, 32'h22, 32'h33, 8'h41, k + 7 + MIN_GAP - 1, -1);
        push_cmd(8'h43, 32'd384, 32'd191991292, 32'd12331, 8'h58);
        push_cmd(8'h77, 32'h11, 32'h22, 32'h33, 8'h41);
        wait_to(k + 7);
        bridge_done = 1'b1;
        @(negedge clk);
        bridge_done = 1'b0;
        wait_drain(100);

        // 3: blocking 'C' with no completion -> timeout, queue resumes
        k = cyc;
        s = k + 2;
        expect_strobe(8'h43, 32'hA, 32'hB, 32'hC, 8'h54, s, -1);
        expect_strobe(8'h6C, 32'hDEAD, 32'hBEEF, 32'hCAFE, 8'h55, s + TIMEOUT + 2, -1);
        push_cmd(8'h43, 32'hA, 32'hB, 32'hC, 8'h54);
        push_cmd(8'h6C, 32'hDEAD, 32'hBEEF, 32'hCAFE, 8'h55);
        wait_to(s + TIMEOUT - 1);
        check("t3_timeout_early", err_timeout, 0);
        wait_to(s + TIMEOUT);
        check("t3_timeout", err_timeout, 1);
        wait_drain(100);
`ifdef NVMAIN_CMD_STATS_EN
        check("t3_stat_issued", stat_issued, 5);
        check("t3_stat_timeout", stat_timeout, 1);
`endif

        // 4: illegal 0x5A between two 'w' is dropped and costs one cycle
        check("t4_illegal_before", err_illegal, 0);
        k = cyc;
        expect_strobe(8'h77, 32'h1, 32'h2, 32'h3, 8'h61, k + 2, -1);
        expect_strobe(8'h77, 32'h4, 32'h5, 32'h6, 8'h62, -1, MIN_GAP + 1);
        push_cmd(8'h77, 32'h1, 32'h2, 32'h3, 8'h61);
        push_cmd(8'h5A, 32'h7, 32'h8, 32'h9, 8'h63);
        push_cmd(8'h77, 32'h4, 32'h5, 32'h6, 8'h62);
        wait_drain(100);
        check("t4_illegal", err_illegal, 1);
        check("t4_timeout_sticky", err_timeout, 1);
`ifdef NVMAIN_CMD_STATS_EN
        check("t4_stat_issued", stat_issued, 7);
        check("t4_stat_illegal", stat_illegal, 1);
        check("t4_stat_timeout", stat_timeout, 1);
`endif

        // 5: fill the FIFO while the bridge is busy, then drain in order
        bridge_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_strobe(t5_ops[i], 32'(100 + i), 32'(200 + i), 32'(300 + i), 8'(8'h30 + i),
                          -1, (i == 0) ? -1 : MIN_GAP);
            push_cmd(t5_ops[i], 32'(100 + i), 32'(200 + i), 32'(300 + i), 8'(8'h30 + i));
        end
        check("t5_full", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = 8'h72;
        cmd_arg1  = 32'd999;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t5_still_full", cmd_ready, 0);
        check("t5_not_idle", idle, 0);
        k = cyc;
        bridge_busy = 1'b0;
        wait_to(k + 1);
        check("t5_first_strobe", command_enable, 1);
        wait_drain(200);
        check("t5_ready_after", cmd_ready, 1);

        // 6: reset during S_WAIT with three queued commands
        k = cyc;
        expect_strobe(8'h52, 32'h77, 32'h88, 32'h99, 8'h5A, k + 2, -1);
        push_cmd(8'h52, 32'h77, 32'h88, 32'h99, 8'h5A);
        push_cmd(8'h77, 32'h1, 32'h1, 32'h1, 8'h01);
        push_cmd(8'h6C, 32'h2, 32'h2, 32'h2, 8'h02);
        push_cmd(8'h63, 32'h3, 32'h3, 32'h3, 8'h03);
        wait_to(k + 10);
        check("t6_waiting", idle, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_idle", idle, 1);
        check("t6_errs", {err_illegal, err_timeout}, 0);
        check("t6_args", {arg0, arg1, arg2, arg3, arg4}, 0);
`ifdef NVMAIN_CMD_STATS_EN
        check("t6_stats", {stat_issued, stat_illegal, stat_timeout}, 0);
`endif
        repeat (40) @(negedge clk);
        check("t6_idle_after", idle, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
